// File: rtl/regfile_bypass_clr_pkg.sv
// Shared types and default widths for the decode-stage register file.
package rf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_bypass_clr_if.sv
// Decode-side bus of the register file: read/write requests in, registered read data out.
interface regfile_bypass_clr_if #(
  parameter int DATA_W = rf_pkg::DATA_W_DEF,
  parameter int ADDR_W = rf_pkg::ADDR_W_DEF
);

  logic              REGWRITE;
  logic              REGDST;
  logic [ADDR_W-1:0] RS_ADDR;
  logic [ADDR_W-1:0] RT_ADDR;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [DATA_W-1:0] WRITE_DATA;
  logic              RD_EN;
  logic              CLR_REQ;
  logic [DATA_W-1:0] READ_DATA_ONE;
  logic [DATA_W-1:0] READ_DATA_TWO;
  logic [ADDR_W-1:0] DEST_Q;
  logic              CLR_BUSY;
  logic              WR_DROP;

  modport master (
    output REGWRITE, REGDST, RS_ADDR, RT_ADDR, RD_ADDR, WRITE_DATA, RD_EN, CLR_REQ,
    input  READ_DATA_ONE, READ_DATA_TWO, DEST_Q, CLR_BUSY, WR_DROP
  );

  modport slave (
    input  REGWRITE, REGDST, RS_ADDR, RT_ADDR, RD_ADDR, WRITE_DATA, RD_EN, CLR_REQ,
    output READ_DATA_ONE, READ_DATA_TWO, DEST_Q, CLR_BUSY, WR_DROP
  );

endinterface

// File: rtl/regfile_bypass_clr_clear_seq.sv
// Soft-clear sequencer: sweeps one word per cycle for DEPTH cycles; ignores new requests
// while sweeping and flags writes that arrive during the sweep one cycle later.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  input  logic              regwrite_i,
  output logic              clr_active_o,
  output logic [ADDR_W-1:0] clr_ptr_o,
  output logic              clr_busy_o,
  output logic              wr_drop_o
);

  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              drop_q, drop_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = regwrite_i && (state_q == CLEAR);
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // The last word is cleared on the exit edge, so the pointer never wraps.
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_active_o = (state_q == CLEAR);
  assign clr_ptr_o    = ptr_q;
  assign clr_busy_o   = (state_q == CLEAR);
  assign wr_drop_o    = drop_q;

endmodule

// File: rtl/regfile_bypass_clr.sv
// 2R1W register file with write/clear bypass, optional zero register and read stall.
// Reads have one-cycle latency; RD_EN=0 holds the read outputs and DEST_Q.
module regfile_bypass_clr
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input logic                CLK,
  input logic                RST_N,
  regfile_bypass_clr_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_active;
  logic              clr_busy;
  logic              wr_drop;
  logic              wr_acc;
  logic [DATA_W-1:0] rd1_d, rd1_q;
  logic [DATA_W-1:0] rd2_d, rd2_q;
  logic [ADDR_W-1:0] dest_addr_q;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .clr_req_i   (bus.CLR_REQ),
    .regwrite_i  (bus.REGWRITE),
    .clr_active_o(clr_active),
    .clr_ptr_o   (clr_ptr),
    .clr_busy_o  (clr_busy),
    .wr_drop_o   (wr_drop)
  );

  assign wa     = bus.REGDST ? bus.RD_ADDR : bus.RT_ADDR;
  assign wr_acc = bus.REGWRITE && !clr_active && !is_zero(wa);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wa] <= bus.WRITE_DATA;
    end else if (clr_active) begin
      mem_q[clr_ptr] <= '0;
    end
  end

  // Later assignments take priority: zero register, then write bypass, then clear bypass.
  always_comb begin
    rd1_d = mem_q[bus.RS_ADDR];
    if (clr_active && (clr_ptr == bus.RS_ADDR)) rd1_d = '0;
    if (wr_acc && (wa == bus.RS_ADDR))          rd1_d = bus.WRITE_DATA;
    if (is_zero(bus.RS_ADDR))                   rd1_d = '0;

    rd2_d = mem_q[bus.RT_ADDR];
    if (clr_active && (clr_ptr == bus.RT_ADDR)) rd2_d = '0;
    if (wr_acc && (wa == bus.RT_ADDR))          rd2_d = bus.WRITE_DATA;
    if (is_zero(bus.RT_ADDR))                   rd2_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      dest_addr_q <= '0;
    end else if (bus.RD_EN) begin
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      dest_addr_q <= bus.RD_ADDR;
    end
  end

  assign bus.READ_DATA_ONE = rd1_q;
  assign bus.READ_DATA_TWO = rd2_q;
  assign bus.DEST_Q        = dest_addr_q;
  assign bus.CLR_BUSY      = clr_busy;
  assign bus.WR_DROP       = wr_drop;

endmodule

// File: tb/tb_regfile_bypass_clr.sv
// Bench for regfile_bypass_clr: a ZERO_REG=0 and a ZERO_REG=1 instance share stimulus,
// directed scenarios use fixed expectations, random traffic is scored against a word-array model.
module tb_regfile_bypass_clr;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  regfile_bypass_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  regfile_bypass_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus1.REGWRITE   = bus0.REGWRITE;
  assign bus1.REGDST     = bus0.REGDST;
  assign bus1.RS_ADDR    = bus0.RS_ADDR;
  assign bus1.RT_ADDR    = bus0.RT_ADDR;
  assign bus1.RD_ADDR    = bus0.RD_ADDR;
  assign bus1.WRITE_DATA = bus0.WRITE_DATA;
  assign bus1.RD_EN      = bus0.RD_EN;
  assign bus1.CLR_REQ    = bus0.CLR_REQ;

  regfile_bypass_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus0)
  );

  regfile_bypass_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus1)
  );

  logic [DW-1:0] o_rd1  [2];
  logic [DW-1:0] o_rd2  [2];
  logic [AW-1:0] o_dest [2];
  logic          o_busy [2];
  logic          o_drop [2];

  assign o_rd1[0]  = bus0.READ_DATA_ONE;
  assign o_rd1[1]  = bus1.READ_DATA_ONE;
  assign o_rd2[0]  = bus0.READ_DATA_TWO;
  assign o_rd2[1]  = bus1.READ_DATA_TWO;
  assign o_dest[0] = bus0.DEST_Q;
  assign o_dest[1] = bus1.DEST_Q;
  assign o_busy[0] = bus0.CLR_BUSY;
  assign o_busy[1] = bus1.CLR_BUSY;
  assign o_drop[0] = bus0.WR_DROP;
  assign o_drop[1] = bus1.WR_DROP;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: word contents plus the number of sweep cycles still to run (0 = idle).
  logic [DW-1:0] m_mem  [2][DEPTH];
  int            m_left [2];
  logic [DW-1:0] m_rd1  [2];
  logic [DW-1:0] m_rd2  [2];
  logic [AW-1:0] m_dest [2];
  logic          m_drop [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < DEPTH; a++) m_mem[i][a] = '0;
      m_left[i] = 0;
      m_rd1[i]  = '0;
      m_rd2[i]  = '0;
      m_dest[i] = '0;
      m_drop[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] mval(int inst, logic [AW-1:0] a, logic wacc,
                                         logic [AW-1:0] wa, logic [DW-1:0] wd);
    if (inst == 1 && a == 0) return '0;
    if (wacc && wa == a) return wd;
    if (m_left[inst] != 0 && (DEPTH - m_left[inst]) == int'(a)) return '0;
    return m_mem[inst][a];
  endfunction

  task automatic drive_idle();
    bus0.REGWRITE   = 1'b0;
    bus0.REGDST     = 1'b0;
    bus0.RS_ADDR    = '0;
    bus0.RT_ADDR    = '0;
    bus0.RD_ADDR    = '0;
    bus0.WRITE_DATA = '0;
    bus0.RD_EN      = 1'b1;
    bus0.CLR_REQ    = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUTs.
  task automatic step();
    logic [AW-1:0] wa;
    logic          idle;
    logic          wacc;
    logic [DW-1:0] v1, v2;
    wa = bus0.REGDST ? bus0.RD_ADDR : bus0.RT_ADDR;
    for (int i = 0; i < 2; i++) begin
      idle = (m_left[i] == 0);
      wacc = bus0.REGWRITE && idle && !(i == 1 && wa == 0);
      v1 = mval(i, bus0.RS_ADDR, wacc, wa, bus0.WRITE_DATA);
      v2 = mval(i, bus0.RT_ADDR, wacc, wa, bus0.WRITE_DATA);
      if (bus0.RD_EN) begin
        m_rd1[i]  = v1;
        m_rd2[i]  = v2;
        m_dest[i] = bus0.RD_ADDR;
      end
      m_drop[i] = bus0.REGWRITE && !idle;
      if (wacc) m_mem[i][wa] = bus0.WRITE_DATA;
      else if (!idle) m_mem[i][DEPTH - m_left[i]] = '0;
      if (idle) m_left[i] = bus0.CLR_REQ ? DEPTH : 0;
      else m_left[i] = m_left[i] - 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(logic [AW-1:0] a, logic [DW-1:0] d);
    bus0.REGWRITE   = 1'b1;
    bus0.REGDST     = 1'b1;
    bus0.RD_ADDR    = a;
    bus0.WRITE_DATA = d;
    step();
    bus0.REGWRITE   = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    RST_N = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (o_rd1[i] !== '0) $display("FAIL reset_rd1[%0d]: got %h want 00", i, o_rd1[i]); else n_pass++;
      n_checks++; if (o_rd2[i] !== '0) $display("FAIL reset_rd2[%0d]: got %h want 00", i, o_rd2[i]); else n_pass++;
      n_checks++; if (o_dest[i] !== '0) $display("FAIL reset_dest[%0d]: got %h want 0", i, o_dest[i]); else n_pass++;
      n_checks++; if (o_busy[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", i, o_busy[i]); else n_pass++;
      n_checks++; if (o_drop[i] !== 1'b0) $display("FAIL reset_drop[%0d]: got %b want 0", i, o_drop[i]); else n_pass++;
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_write_read();
    write_reg(2'd2, 8'hA5);
    bus0.RS_ADDR = 2'd2;
    bus0.RD_ADDR = 2'd3;
    step();
    n_checks++; if (o_rd1[0] !== 8'hA5) $display("FAIL wr_rd_data: got %h want a5", o_rd1[0]); else n_pass++;
    n_checks++; if (o_dest[0] !== 2'd3) $display("FAIL wr_rd_dest: got %0d want 3", o_dest[0]); else n_pass++;
    bus0.RD_ADDR = 2'd1;
    step();
    n_checks++; if (o_dest[0] !== 2'd1) $display("FAIL dest_track: got %0d want 1", o_dest[0]); else n_pass++;
  endtask

  task automatic test_bypass();
    bus0.REGWRITE   = 1'b1;
    bus0.REGDST     = 1'b0;
    bus0.RT_ADDR    = 2'd1;
    bus0.RS_ADDR    = 2'd1;
    bus0.WRITE_DATA = 8'h3C;
    step();
    bus0.REGWRITE = 1'b0;
    n_checks++; if (o_rd1[0] !== 8'h3C) $display("FAIL bypass_rd1: got %h want 3c", o_rd1[0]); else n_pass++;
    n_checks++; if (o_rd2[0] !== 8'h3C) $display("FAIL bypass_rd2: got %h want 3c", o_rd2[0]); else n_pass++;
  endtask

  task automatic test_clear();
    int nb;
    for (int a = 0; a < DEPTH; a++) write_reg(a[AW-1:0], 8'(8'h11 * (a + 1)));
    bus0.RS_ADDR = 2'd3;
    bus0.RT_ADDR = 2'd0;
    bus0.CLR_REQ = 1'b1;
    step();
    bus0.CLR_REQ = 1'b0;
    nb = 0;
    for (int k = 0; k < 20 && o_busy[0]; k++) begin
      nb++;
      if (nb == 3) begin
        n_checks++; if (o_rd1[0] !== 8'h44) $display("FAIL clear_mid_read: got %h want 44", o_rd1[0]); else n_pass++;
      end
      step();
    end
    n_checks++; if (nb != DEPTH) $display("FAIL clear_busy_len: got %0d want %0d", nb, DEPTH); else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      bus0.RS_ADDR = a[AW-1:0];
      bus0.RT_ADDR = a[AW-1:0];
      step();
      n_checks++; if (o_rd1[0] !== '0) $display("FAIL clear_word1[%0d]: got %h want 00", a, o_rd1[0]); else n_pass++;
      n_checks++; if (o_rd2[0] !== '0) $display("FAIL clear_word2[%0d]: got %h want 00", a, o_rd2[0]); else n_pass++;
    end
  endtask

  task automatic test_drop();
    bus0.RS_ADDR = 2'd0;
    bus0.CLR_REQ = 1'b1;
    step();
    bus0.CLR_REQ    = 1'b0;
    bus0.REGWRITE   = 1'b1;
    bus0.REGDST     = 1'b1;
    bus0.RD_ADDR    = 2'd0;
    bus0.WRITE_DATA = 8'hFF;
    step();
    bus0.REGWRITE = 1'b0;
    n_checks++; if (o_drop[0] !== 1'b1) $display("FAIL drop_pulse: got %b want 1", o_drop[0]); else n_pass++;
    step();
    n_checks++; if (o_drop[0] !== 1'b0) $display("FAIL drop_end: got %b want 0", o_drop[0]); else n_pass++;
    for (int k = 0; k < 20 && o_busy[0]; k++) step();
    n_checks++; if (o_busy[0] !== 1'b0) $display("FAIL drop_busy_done: got %b want 0", o_busy[0]); else n_pass++;
    step();
    n_checks++; if (o_rd1[0] !== '0) $display("FAIL drop_reg0: got %h want 00", o_rd1[0]); else n_pass++;
  endtask

  task automatic test_zero_reg();
    bus0.REGWRITE   = 1'b1;
    bus0.REGDST     = 1'b1;
    bus0.RD_ADDR    = 2'd0;
    bus0.WRITE_DATA = 8'h77;
    bus0.RS_ADDR    = 2'd0;
    step();
    bus0.REGWRITE = 1'b0;
    n_checks++; if (o_rd1[1] !== '0) $display("FAIL zero_bypass: got %h want 00", o_rd1[1]); else n_pass++;
    n_checks++; if (o_rd1[0] !== 8'h77) $display("FAIL nonzero_bypass: got %h want 77", o_rd1[0]); else n_pass++;
    step();
    n_checks++; if (o_rd1[1] !== '0) $display("FAIL zero_read: got %h want 00", o_rd1[1]); else n_pass++;
    n_checks++; if (o_drop[1] !== 1'b0) $display("FAIL zero_drop: got %b want 0", o_drop[1]); else n_pass++;
    n_checks++; if (o_rd1[0] !== 8'h77) $display("FAIL nonzero_read: got %h want 77", o_rd1[0]); else n_pass++;
  endtask

  task automatic test_stall();
    write_reg(2'd2, 8'h96);
    write_reg(2'd3, 8'h69);
    bus0.RS_ADDR = 2'd2;
    bus0.RT_ADDR = 2'd3;
    bus0.RD_ADDR = 2'd2;
    step();
    bus0.RD_EN   = 1'b0;
    bus0.RS_ADDR = 2'd1;
    bus0.RT_ADDR = 2'd0;
    bus0.RD_ADDR = 2'd1;
    step();
    step();
    n_checks++; if (o_rd1[0] !== 8'h96) $display("FAIL stall_rd1: got %h want 96", o_rd1[0]); else n_pass++;
    n_checks++; if (o_rd2[0] !== 8'h69) $display("FAIL stall_rd2: got %h want 69", o_rd2[0]); else n_pass++;
    n_checks++; if (o_dest[0] !== 2'd2) $display("FAIL stall_dest: got %0d want 2", o_dest[0]); else n_pass++;
    bus0.RD_EN = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus0.REGWRITE   = 1'($urandom_range(0, 1));
      bus0.REGDST     = 1'($urandom_range(0, 1));
      bus0.RS_ADDR    = 2'($urandom_range(0, 3));
      bus0.RT_ADDR    = 2'($urandom_range(0, 3));
      bus0.RD_ADDR    = 2'($urandom_range(0, 3));
      bus0.WRITE_DATA = 8'($urandom);
      bus0.RD_EN      = ($urandom_range(0, 3) != 0);
      bus0.CLR_REQ    = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (o_rd1[i] !== m_rd1[i]) $display("FAIL rand_rd1[%0d] n=%0d: got %h want %h", i, n, o_rd1[i], m_rd1[i]); else n_pass++;
        n_checks++; if (o_rd2[i] !== m_rd2[i]) $display("FAIL rand_rd2[%0d] n=%0d: got %h want %h", i, n, o_rd2[i], m_rd2[i]); else n_pass++;
        n_checks++; if (o_dest[i] !== m_dest[i]) $display("FAIL rand_dest[%0d] n=%0d: got %h want %h", i, n, o_dest[i], m_dest[i]); else n_pass++;
        n_checks++; if (o_busy[i] !== (m_left[i] != 0)) $display("FAIL rand_busy[%0d] n=%0d: got %b want %b", i, n, o_busy[i], (m_left[i] != 0)); else n_pass++;
        n_checks++; if (o_drop[i] !== m_drop[i]) $display("FAIL rand_drop[%0d] n=%0d: got %b want %b", i, n, o_drop[i], m_drop[i]); else n_pass++;
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_clear();
    drive_idle();
    for (int k = 0; k < 20 && o_busy[0]; k++) step();
    write_reg(2'd1, 8'h5A);
    bus0.RS_ADDR = 2'd1;
    bus0.RD_ADDR = 2'd3;
    bus0.CLR_REQ = 1'b1;
    step();
    bus0.CLR_REQ    = 1'b0;
    bus0.REGWRITE   = 1'b1;
    bus0.WRITE_DATA = 8'hEE;
    step();
    bus0.REGWRITE = 1'b0;
    n_checks++; if (o_busy[0] !== 1'b1) $display("FAIL pre_rst_busy: got %b want 1", o_busy[0]); else n_pass++;
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (o_rd1[i] !== '0) $display("FAIL async_rst_rd1[%0d]: got %h want 00", i, o_rd1[i]); else n_pass++;
      n_checks++; if (o_dest[i] !== '0) $display("FAIL async_rst_dest[%0d]: got %h want 0", i, o_dest[i]); else n_pass++;
      n_checks++; if (o_busy[i] !== 1'b0) $display("FAIL async_rst_busy[%0d]: got %b want 0", i, o_busy[i]); else n_pass++;
      n_checks++; if (o_drop[i] !== 1'b0) $display("FAIL async_rst_drop[%0d]: got %b want 0", i, o_drop[i]); else n_pass++;
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bus0.RS_ADDR = a[AW-1:0];
      bus0.RT_ADDR = 2'(DEPTH - 1 - a);
      step();
      n_checks++; if (o_rd1[0] !== '0) $display("FAIL post_rst_word1[%0d]: got %h want 00", a, o_rd1[0]); else n_pass++;
      n_checks++; if (o_rd2[0] !== '0) $display("FAIL post_rst_word2[%0d]: got %h want 00", DEPTH - 1 - a, o_rd2[0]); else n_pass++;
      n_checks++; if (o_busy[0] !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", o_busy[0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_drop();
    test_zero_reg();
    test_stall();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
